// File: rtl/muldiv_if.sv
// Issue/read/result bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side is the master; the unit owning HI/LO is the slave.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_div;
  logic             is_signed;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             rd_hi;
  logic             rd_lo;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_div, is_signed, srca, srcb, rd_hi, rd_lo,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, is_div, is_signed, srca, srcb, rd_hi, rd_lo,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the MIPS HI/LO pair.
// Operands are processed as magnitudes; signs are reapplied in a single FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      counter;
  logic [WIDTH-1:0]   opa, opb;
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               op_div, neg_q, neg_r, done_q;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] product, mul_res;
  logic [WIDTH-1:0]   div_q, div_r, res_hi, res_lo;

  // Operand magnitudes at issue, and the per-iteration adder/subtractor.
  always_comb begin
    sign_a   = bus.is_signed & bus.srca[WIDTH-1];
    sign_b   = bus.is_signed & bus.srcb[WIDTH-1];
    abs_a    = sign_a ? -bus.srca : bus.srca;
    abs_b    = sign_b ? -bus.srcb : bus.srcb;
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
    div_diff = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, opb};
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient while the
  // remainder path naturally reproduces the dividend as issued.
  always_comb begin
    product = {acc_hi, acc_lo};
    mul_res = neg_q ? -product : product;
    div_q   = neg_q ? -acc_lo : acc_lo;
    div_r   = neg_r ? -acc_hi : acc_hi;
    res_hi  = op_div ? div_r : mul_res[2*WIDTH-1:WIDTH];
    res_lo  = op_div ? ((opb == '0) ? '1 : div_q) : mul_res[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (counter == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiply shifts right through {acc_hi,acc_lo}; divide shifts the dividend
  // out of acc_lo MSB-first while quotient bits enter at its LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      opa     <= '0;
      opb     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            counter <= '0;
            opa     <= abs_a;
            opb     <= abs_b;
            op_div  <= bus.is_div;
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            acc_hi  <= '0;
            acc_lo  <= bus.is_div ? abs_a : abs_b;
          end
        end
        RUN: begin
          counter <= counter + 1'b1;
          if (op_div) begin
            if (!div_diff[WIDTH+1]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.rd_hi | bus.rd_lo);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule
